circuit1_exhaustive_checker: RTL and testbench
==============================================

// Module: circuit1_exhaustive_checker
//
// PURPOSE
// Upstream stimulus/downstream compare stage for the circuit1 implementations.
// On start, walks test_input through every WIDTH-bit pattern in ascending order.
// Holds each pattern HOLD_CYCLES clocks, then compares f1 (structural) against f2 (dataflow).
// Counts disagreements, captures the first failing pattern, then asserts done.
//
// PARAMETERS
// WIDTH        3   width of test_input; 2**WIDTH patterns are applied (WIDTH >= 1)
// HOLD_CYCLES  5   clocks each pattern is held before compare (HOLD_CYCLES >= 1)
//
// PORTS
// clk             input   1         single clock, rising edge
// reset           input   1         synchronous, active-high reset
// start           input   1         begin a sweep; sampled only in IDLE or DONE
// f1              input   1         output of the structural implementation
// f2              input   1         output of the dataflow implementation
// test_input      output  WIDTH     registered pattern driven to both implementations
// busy            output  1         high while a sweep is in progress
// done            output  1         high from sweep completion until start or reset
// mismatch        output  1         sticky; high once any compare has failed
// mismatch_count  output  WIDTH+1   number of failing patterns (0 .. 2**WIDTH)
// first_fail_vec  output  WIDTH     pattern of the first failing compare; 0 if none
//
// BEHAVIOUR
// - One clock (clk). Reset is synchronous and active-high (reset).
// - Reset values: state = IDLE, test_input = 0, busy = 0, done = 0, mismatch = 0,
//   mismatch_count = 0, first_fail_vec = 0, hold counter = 0.
// - Reset has priority over everything, including a sweep in progress; it aborts the sweep.
// - FSM states:
//   - IDLE -> RUN on start.
//   - RUN  -> DONE after the last pattern has been compared.
//   - DONE -> RUN on start; otherwise DONE holds.
// - Entering RUN (IDLE or DONE with start = 1): on the next edge,
//   - test_input = 0 and busy = 1;
//   - mismatch, mismatch_count, first_fail_vec and the hold counter are cleared;
//   - done = 0.
// - In RUN:
//   - The hold counter counts 0 .. HOLD_CYCLES-1.
//   - On the edge where the counter is HOLD_CYCLES-1, f1 != f2 is evaluated for the current test_input:
//     - on a failure, mismatch_count increments and mismatch is set;
//     - on the first failure only, first_fail_vec is loaded with test_input.
//   - On that same edge, if test_input != all-ones: test_input increments and the counter returns to 0.
//   - If test_input == all-ones: go to DONE, busy = 0, done = 1; test_input holds at all-ones.
// - start is ignored while in RUN.
// - Timing: with start seen at edge k, busy is high for exactly (2**WIDTH)*HOLD_CYCLES cycles,
//   and done rises at edge k + (2**WIDTH)*HOLD_CYCLES + 1.
// - HOLD_CYCLES = 1: every pattern is compared one cycle after it is driven; no idle gap.
// - mismatch_count saturation cannot occur (the WIDTH+1 bit width holds 2**WIDTH).
// - f1/f2 are assumed settled within one cycle. They are sampled only at the compare edge;
//   glitches at any other time are ignored.
//
// TESTING
// 1. Matching implementations, WIDTH=3, HOLD=5, start at cycle 2
//    -> test_input steps 0..7, 5 cycles each; done at cycle 43; mismatch=0, count=0, first_fail_vec=0.
// 2. f2 forced inverted only when test_input==3'b101
//    -> mismatch=1, mismatch_count=1, first_fail_vec=3'b101, done still asserted.
// 3. f2 tied to ~f1 -> mismatch_count=8, first_fail_vec=3'b000.
// 4. reset pulsed during pattern 3'b011
//    -> next edge: all outputs at reset values, state IDLE; a later start performs a full clean sweep.
// 5. start held high throughout RUN; start asserted again in DONE
//    -> the RUN start is ignored; the DONE start clears done/count and restarts at 3'b000.
// 6. HOLD_CYCLES=1 -> busy high for exactly 8 cycles; one compare per cycle; totals as in case 1.

Source files
------------

// File: rtl/circuit1_exhaustive_checker.sv
// Exhaustive stimulus/compare stage: sweeps test_input through every WIDTH-bit pattern,
// compares the two circuit1 implementations after each hold window and records failures.
module circuit1_exhaustive_checker #(
    parameter int WIDTH       = 3,
    parameter int HOLD_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             f1,
    input  logic             f2,
    output logic [WIDTH-1:0] test_input,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [WIDTH:0]   mismatch_count,
    output logic [WIDTH-1:0] first_fail_vec
);

    // A one-bit counter is kept even when HOLD_CYCLES is 1 so the compare term stays uniform.
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [WIDTH-1:0] VEC_LAST  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] VEC_ONE   = WIDTH'(1'b1);
    localparam logic [WIDTH:0]   COUNT_ONE = (WIDTH + 1)'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
    logic [WIDTH-1:0] test_input_r, test_input_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             mismatch_r, mismatch_s;
    logic [WIDTH:0]   count_r, count_s;
    logic [WIDTH-1:0] first_fail_r, first_fail_s;
    logic             compare_fail_s;

    assign compare_fail_s = (f1 != f2);

    // Next-state and next-datapath values; every register holds unless a transition updates it.
    always_comb begin
        state_s      = state_r;
        hold_cnt_s   = hold_cnt_r;
        test_input_s = test_input_r;
        busy_s       = busy_r;
        done_s       = done_r;
        mismatch_s   = mismatch_r;
        count_s      = count_r;
        first_fail_s = first_fail_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s      = ST_RUN;
                    hold_cnt_s   = '0;
                    test_input_s = '0;
                    busy_s       = 1'b1;
                    done_s       = 1'b0;
                    mismatch_s   = 1'b0;
                    count_s      = '0;
                    first_fail_s = '0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (hold_cnt_r == CNT_LAST) begin
                    // first_fail uses the old sticky flag so only the earliest failure is captured
                    if (compare_fail_s) begin
                        count_s    = count_r + COUNT_ONE;
                        mismatch_s = 1'b1;
                        if (!mismatch_r) begin
                            first_fail_s = test_input_r;
                        end else begin
                            first_fail_s = first_fail_r;
                        end
                    end else begin
                        count_s = count_r;
                    end
                    if (test_input_r == VEC_LAST) begin
                        state_s = ST_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        test_input_s = test_input_r + VEC_ONE;
                        hold_cnt_s   = '0;
                    end
                end else begin
                    hold_cnt_s = hold_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority over any sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            hold_cnt_r   <= '0;
            test_input_r <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            mismatch_r   <= 1'b0;
            count_r      <= '0;
            first_fail_r <= '0;
        end else begin
            state_r      <= state_s;
            hold_cnt_r   <= hold_cnt_s;
            test_input_r <= test_input_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            mismatch_r   <= mismatch_s;
            count_r      <= count_s;
            first_fail_r <= first_fail_s;
        end
    end

    assign test_input     = test_input_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign mismatch       = mismatch_r;
    assign mismatch_count = count_r;
    assign first_fail_vec = first_fail_r;

endmodule

// File: tb/tb_circuit1_exhaustive_checker.sv
// Scoreboard bench: two checker instances (hold 5 and hold 1) driven by randomized truth
// tables with planted faults; a per-instance monitor scores each completed sweep.
module tb_circuit1_exhaustive_checker;

    localparam int W  = 3;
    localparam int N  = 8;
    localparam int HA = 5;
    localparam int HB = 1;

    typedef struct {
        int count;
        int first;
        int mism;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a, start_a, f1_a, f2_a, busy_a, done_a, mm_a, gl_a;
    logic [W-1:0] ti_a, ffv_a;
    logic [W:0]   cnt_a;
    logic         rst_b, start_b, f1_b, f2_b, busy_b, done_b, mm_b;
    logic [W-1:0] ti_b, ffv_b;
    logic [W:0]   cnt_b;

    logic [N-1:0] truth_a = '0, fault_a = '0, truth_b = '0, fault_b = '0;
    bit           glitch_a = 1'b0;
    bit           done_prev_a = 1'b0, done_prev_b = 1'b0;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t exp_a[$], exp_b[$];
    int   seen_a[$], seen_b[$];

    // The implementations under compare: f1 is the truth table, f2 adds the planted fault
    // plus (for instance A) random glitching outside the compare cycle.
    assign f1_a = truth_a[ti_a];
    assign f2_a = truth_a[ti_a] ^ fault_a[ti_a] ^ gl_a;
    assign f1_b = truth_b[ti_b];
    assign f2_b = truth_b[ti_b] ^ fault_b[ti_b];

    circuit1_exhaustive_checker #(.WIDTH(W), .HOLD_CYCLES(HA)) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .f1(f1_a), .f2(f2_a),
        .test_input(ti_a), .busy(busy_a), .done(done_a), .mismatch(mm_a),
        .mismatch_count(cnt_a), .first_fail_vec(ffv_a)
    );

    circuit1_exhaustive_checker #(.WIDTH(W), .HOLD_CYCLES(HB)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .f1(f1_b), .f2(f2_b),
        .test_input(ti_b), .busy(busy_b), .done(done_b), .mismatch(mm_b),
        .mismatch_count(cnt_b), .first_fail_vec(ffv_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference: a pattern fails iff its fault bit is set; results follow by counting.
    function automatic exp_t model(input logic [N-1:0] fault);
        exp_t e;
        e.count = 0;
        e.first = 0;
        for (int p = 0; p < N; p++) begin
            if (fault[p]) begin
                if (e.count == 0) e.first = p;
                e.count++;
            end
        end
        e.mism = (e.count != 0) ? 1 : 0;
        return e;
    endfunction

    task automatic score(input string tag, input exp_t e, input int seen[$], input int hold,
                         input int cnt, input int first, input int mism, input int ti,
                         input int busy);
        int bad;
        bad = 0;
        for (int i = 0; i < seen.size(); i++) begin
            if (seen[i] != i / hold) bad++;
        end
        check({tag, "_busy_cycles"}, seen.size(), N * hold);
        check({tag, "_sequence_errors"}, bad, 0);
        check({tag, "_mismatch_count"}, cnt, e.count);
        check({tag, "_first_fail_vec"}, first, e.first);
        check({tag, "_mismatch"}, mism, e.mism);
        check({tag, "_final_test_input"}, ti, N - 1);
        check({tag, "_busy_at_done"}, busy, 0);
    endtask

    // Monitor A: logs the pattern of every busy cycle, schedules glitches, scores on done rise.
    always @(negedge clk) begin
        if (busy_a) seen_a.push_back(int'(ti_a));
        gl_a <= (glitch_a && busy_a && (((seen_a.size() - 1) % HA) != HA - 1))
                ? 1'($urandom_range(0, 1)) : 1'b0;
        if (done_a && !done_prev_a) begin
            if (exp_a.size() == 0) check("a_unexpected_done", 1, 0);
            else score("a", exp_a.pop_front(), seen_a, HA, int'(cnt_a), int'(ffv_a),
                       int'(mm_a), int'(ti_a), int'(busy_a));
            seen_a.delete();
        end
        done_prev_a <= done_a;
    end

    // Monitor B: same scoring for the single-cycle-hold instance.
    always @(negedge clk) begin
        if (busy_b) seen_b.push_back(int'(ti_b));
        if (done_b && !done_prev_b) begin
            if (exp_b.size() == 0) check("b_unexpected_done", 1, 0);
            else score("b", exp_b.pop_front(), seen_b, HB, int'(cnt_b), int'(ffv_b),
                       int'(mm_b), int'(ti_b), int'(busy_b));
            seen_b.delete();
        end
        done_prev_b <= done_b;
    end

    task automatic wait_done_a();
        int k;
        k = 0;
        while (!done_a && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("a_done_within_budget", int'(done_a), 1);
        repeat (3) @(negedge clk);
        check("a_done_holds", int'({done_a, busy_a}), 2);
    endtask

    task automatic sweep_a(input logic [N-1:0] truth, input logic [N-1:0] fault,
                           input bit glitch, input bit hold_start);
        truth_a  = truth;
        fault_a  = fault;
        glitch_a = glitch;
        exp_a.push_back(model(fault));
        @(negedge clk) start_a = 1'b1;
        @(negedge clk);
        check("a_start_clears", int'({busy_a, done_a, mm_a, cnt_a, ffv_a, ti_a}), 32'h1000);
        if (hold_start) repeat (N * HA - 4) @(negedge clk);
        start_a = 1'b0;
        wait_done_a();
    endtask

    task automatic abort_a();
        int k;
        truth_a  = 8'($urandom);
        fault_a  = 8'($urandom);
        glitch_a = 1'b0;
        exp_a.push_back(model(fault_a));
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        k = 0;
        while (ti_a != 3'b011 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("a_reached_pattern3", int'(ti_a), 3);
        rst_a = 1'b1;
        @(negedge clk);
        check("a_abort_reset_state", int'({ti_a, busy_a, done_a, mm_a, cnt_a, ffv_a}), 0);
        exp_a.delete();
        seen_a.delete();
        rst_a = 1'b0;
        repeat (5) @(negedge clk);
        check("a_idle_after_abort", int'({busy_a, done_a}), 0);
    endtask

    task automatic sweep_b(input logic [N-1:0] truth, input logic [N-1:0] fault);
        int k;
        truth_b = truth;
        fault_b = fault;
        exp_b.push_back(model(fault));
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        check("b_start_clears", int'({busy_b, done_b, mm_b, cnt_b, ffv_b, ti_b}), 32'h1000);
        k = 0;
        while (!done_b && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("b_done_within_budget", int'(done_b), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_a   = 1'b1;
        rst_b   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        check("a_reset_state", int'({ti_a, busy_a, done_a, mm_a, cnt_a, ffv_a}), 0);
        check("b_reset_state", int'({ti_b, busy_b, done_b, mm_b, cnt_b, ffv_b}), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);

        sweep_a(8'($urandom), 8'h00, 1'b0, 1'b0);
        sweep_a(8'($urandom), 8'h20, 1'b0, 1'b0);
        sweep_a(8'($urandom), 8'hFF, 1'b0, 1'b0);
        abort_a();
        sweep_a(8'($urandom), 8'h00, 1'b0, 1'b0);
        sweep_a(8'($urandom), 8'($urandom) | 8'h01, 1'b0, 1'b1);
        sweep_a(8'($urandom), 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) sweep_a(8'($urandom), 8'($urandom), 1'b1, 1'b0);

        sweep_b(8'($urandom), 8'h00);
        sweep_b(8'($urandom), 8'h20);
        sweep_b(8'($urandom), 8'hFF);
        for (int i = 0; i < 3; i++) sweep_b(8'($urandom), 8'($urandom));

        repeat (2) @(negedge clk);
        check("a_pending_expectations", exp_a.size(), 0);
        check("b_pending_expectations", exp_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
